// File: rtl/z80_alu_pkg.sv
// Shared constants and types for the Z80 16-bit arithmetic sequencer.
// Holds the 8-bit ALU opcode encodings, the sequencer op and state enums,
// and the flag bit positions (F register layout S7 Z6 Y5 H4 X3 PV2 N1 C0).
package z80_alu_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned FLAGS_W = 8;

  // 8-bit ALU opcodes
  localparam logic [OPC_W-1:0] ALU_OP_ADD = 5'd0;
  localparam logic [OPC_W-1:0] ALU_OP_ADC = 5'd1;
  localparam logic [OPC_W-1:0] ALU_OP_SUB = 5'd2;
  localparam logic [OPC_W-1:0] ALU_OP_SBC = 5'd3;

  // Flag bit positions
  localparam int unsigned FLAG_S  = 7;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_Y  = 5;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_X  = 3;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_C  = 0;

  typedef enum logic [2:0] {
    SEQ_ADD16 = 3'd0,
    SEQ_ADC16 = 3'd1,
    SEQ_SBC16 = 3'd2,
    SEQ_INC16 = 3'd3,
    SEQ_DEC16 = 3'd4
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Codes 5..7 are reserved
  function automatic logic op_valid(input logic [2:0] op);
    return op <= SEQ_DEC16;
  endfunction

endpackage

// File: rtl/alu16_flag_merge.sv
// Merges the low-pass zero flag and the high-pass flag set into one Z80 F byte.
// Ports:
//   op        latched sequencer op
//   flags_in  F register captured at start
//   lo_z      Z flag of the low-byte pass
//   hi_flags  flag set of the high-byte pass
//   flags_c   merged flags (combinational)
module alu16_flag_merge
  import z80_alu_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic               lo_z,
  input  logic [FLAGS_W-1:0] hi_flags,
  output logic [FLAGS_W-1:0] flags_c
);

  always_comb begin
    flags_c          = '0;
    flags_c[FLAG_S]  = hi_flags[FLAG_S];
    // 16-bit zero only when both bytes were zero
    flags_c[FLAG_Z]  = lo_z & hi_flags[FLAG_Z];
    flags_c[FLAG_Y]  = hi_flags[FLAG_Y];
    flags_c[FLAG_H]  = hi_flags[FLAG_H];
    flags_c[FLAG_X]  = hi_flags[FLAG_X];
    flags_c[FLAG_PV] = hi_flags[FLAG_PV];
    flags_c[FLAG_N]  = hi_flags[FLAG_N];
    flags_c[FLAG_C]  = hi_flags[FLAG_C];
    case (op)
      SEQ_ADD16: begin
        // ADD HL,rr leaves S, Z and PV alone
        flags_c[FLAG_S]  = flags_in[FLAG_S];
        flags_c[FLAG_Z]  = flags_in[FLAG_Z];
        flags_c[FLAG_PV] = flags_in[FLAG_PV];
      end
      SEQ_INC16, SEQ_DEC16: flags_c = flags_in;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu16_sequencer.sv
// Runs Z80 16-bit ADD/ADC/SBC/INC/DEC through the shared 8-bit ALU in two
// passes (low byte, then high byte) with the carry chained between them.
// Optional macro ALU16_SEQ_INCDEC_BYPASS_EN: INC16/DEC16 use a local 16-bit
// incrementer and complete in one cycle without touching the ALU.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, op, a, b      request, op code (0..4 valid), operands
//   flags_in             current F register
//   busy, done           in LO/HI; one-cycle completion pulse
//   result, flags_out    registered result and merged flags
//   alu_a/b/opcode/cin   registered drive to the external 8-bit ALU
//   alu_out, alu_flags   ALU result and flags
module alu16_sequencer
  import z80_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ALU_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] flags_out,
  output logic [ALU_W-1:0]   alu_a,
  output logic [ALU_W-1:0]   alu_b,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic               alu_cin,
  input  logic [ALU_W-1:0]   alu_out,
  input  logic [FLAGS_W-1:0] alu_flags
);

  state_e             state, state_d;
  logic [2:0]         op_q, op_d;
  logic [ALU_W-1:0]   a_hi, a_hi_d, b_hi, b_hi_d;
  logic [ALU_W-1:0]   lo_byte, lo_byte_d;
  logic               lo_z, lo_z_d;
  logic [FLAGS_W-1:0] f_q, f_d, flags_d, merge_c;
  logic [DATA_W-1:0]  result_d;
  logic               busy_d, done_d;
  logic [ALU_W-1:0]   alu_a_d, alu_b_d;
  logic [OPC_W-1:0]   alu_opcode_d;
  logic               alu_cin_d;

  alu16_flag_merge u_merge (
    .op       (op_q),
    .flags_in (f_q),
    .lo_z     (lo_z),
    .hi_flags (alu_flags),
    .flags_c  (merge_c)
  );

  // Next state, datapath updates and the ALU drive for the coming state.
  // ALU controls are registered, so they are computed one cycle early.
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    a_hi_d       = a_hi;
    b_hi_d       = b_hi;
    f_d          = f_q;
    lo_byte_d    = lo_byte;
    lo_z_d       = lo_z;
    result_d     = result;
    flags_d      = flags_out;
    done_d       = 1'b0;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_opcode_d = ALU_OP_ADD;
    alu_cin_d    = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d   = op;
          a_hi_d = a[DATA_W-1:ALU_W];
          b_hi_d = b[DATA_W-1:ALU_W];
          f_d    = flags_in;
          if (!op_valid(op)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = a;
            flags_d  = flags_in;
          end
`ifdef ALU16_SEQ_INCDEC_BYPASS_EN
          else if (op == SEQ_INC16 || op == SEQ_DEC16) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = (op == SEQ_INC16) ? a + DATA_W'(1) : a - DATA_W'(1);
            flags_d  = flags_in;
          end
`endif
          else begin
            state_d = ST_LO;
            alu_a_d = a[ALU_W-1:0];
            case (op)
              SEQ_ADD16: begin
                alu_opcode_d = ALU_OP_ADD;
                alu_b_d      = b[ALU_W-1:0];
              end
              SEQ_ADC16: begin
                alu_opcode_d = ALU_OP_ADC;
                alu_b_d      = b[ALU_W-1:0];
                alu_cin_d    = flags_in[FLAG_C];
              end
              SEQ_SBC16: begin
                alu_opcode_d = ALU_OP_SBC;
                alu_b_d      = b[ALU_W-1:0];
                alu_cin_d    = flags_in[FLAG_C];
              end
              SEQ_INC16: begin
                alu_opcode_d = ALU_OP_ADD;
                alu_b_d      = ALU_W'(1);
              end
              default: begin
                alu_opcode_d = ALU_OP_SUB;
                alu_b_d      = ALU_W'(1);
              end
            endcase
          end
        end else if (state == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_LO: begin
        state_d   = ST_HI;
        lo_byte_d = alu_out;
        lo_z_d    = alu_flags[FLAG_Z];
        alu_a_d   = a_hi;
        // Low-pass carry is held in alu_cin for the high pass
        alu_cin_d = alu_flags[FLAG_C];
        case (op_q)
          SEQ_SBC16, SEQ_DEC16: alu_opcode_d = ALU_OP_SBC;
          default:              alu_opcode_d = ALU_OP_ADC;
        endcase
        alu_b_d = (op_q == SEQ_INC16 || op_q == SEQ_DEC16) ? '0 : b_hi;
      end

      ST_HI: begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        result_d = {alu_out, lo_byte};
        flags_d  = merge_c;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LO) || (state_d == ST_HI);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      a_hi       <= '0;
      b_hi       <= '0;
      f_q        <= '0;
      lo_byte    <= '0;
      lo_z       <= 1'b0;
      result     <= '0;
      flags_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= ALU_OP_ADD;
      alu_cin    <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      a_hi       <= a_hi_d;
      b_hi       <= b_hi_d;
      f_q        <= f_d;
      lo_byte    <= lo_byte_d;
      lo_z       <= lo_z_d;
      result     <= result_d;
      flags_out  <= flags_d;
      busy       <= busy_d;
      done       <= done_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_opcode <= alu_opcode_d;
      alu_cin    <= alu_cin_d;
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer with a behavioural 8-bit Z80 ALU
// and a 16-bit reference model feeding a queue of expected {result, flags}.
module tb_alu16_sequencer;

`ifdef ALU16_SEQ_INCDEC_BYPASS_EN
  localparam int INCDEC_LAT = 1;
`else
  localparam int INCDEC_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [7:0]  flags_in;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flags_out;
  logic [7:0]  alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic        alu_cin;
  logic [7:0]  alu_out, alu_flags;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] ex;
  int          lat;

  always #5 clk = ~clk;

  alu16_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result),
    .flags_out(flags_out), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_out(alu_out),
    .alu_flags(alu_flags)
  );

  // Behavioural 8-bit ALU: 0 ADD, 1 ADC, 2 SUB, 3 SBC
  logic [8:0] m_s;
  logic [4:0] m_h;
  logic       m_c, m_sub, m_v;
  always_comb begin
    m_sub = (alu_opcode == 5'd2) || (alu_opcode == 5'd3);
    m_c   = ((alu_opcode == 5'd1) || (alu_opcode == 5'd3)) ? alu_cin : 1'b0;
    if (m_sub) begin
      m_s = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, m_c};
      m_h = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, m_c};
      m_v = (alu_a[7] != alu_b[7]) && (m_s[7] != alu_a[7]);
    end else begin
      m_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, m_c};
      m_h = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, m_c};
      m_v = (alu_a[7] == alu_b[7]) && (m_s[7] != alu_a[7]);
    end
    alu_out   = m_s[7:0];
    alu_flags = {m_s[7], m_s[7:0] == 8'd0, m_s[5], m_h[4], m_s[3], m_v, m_sub, m_s[8]};
  end

  // 16-bit Z80 reference: returns {result, flags}
  function automatic logic [23:0] ref16(input logic [2:0] o, input logic [15:0] av,
                                        input logic [15:0] bv, input logic [7:0] f);
    logic [16:0] s;
    logic [12:0] h;
    logic [15:0] r;
    logic [7:0]  fo;
    logic        c;
    c = (o == 3'd0) ? 1'b0 : f[0];
    case (o)
      3'd0, 3'd1: begin
        s  = {1'b0, av} + {1'b0, bv} + {16'd0, c};
        h  = {1'b0, av[11:0]} + {1'b0, bv[11:0]} + {12'd0, c};
        r  = s[15:0];
        fo = {r[15], r == 16'd0, r[13], h[12], r[11],
              (av[15] == bv[15]) && (r[15] != av[15]), 1'b0, s[16]};
        if (o == 3'd0) begin
          fo[7] = f[7]; fo[6] = f[6]; fo[2] = f[2];
        end
      end
      3'd2: begin
        s  = {1'b0, av} - {1'b0, bv} - {16'd0, c};
        h  = {1'b0, av[11:0]} - {1'b0, bv[11:0]} - {12'd0, c};
        r  = s[15:0];
        fo = {r[15], r == 16'd0, r[13], h[12], r[11],
              (av[15] != bv[15]) && (r[15] != av[15]), 1'b1, s[16]};
      end
      3'd3:    begin r = av + 16'd1; fo = f; end
      3'd4:    begin r = av - 16'd1; fo = f; end
      default: begin r = av;         fo = f; end
    endcase
    return {r, fo};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [7:0] fv, input logic [23:0] e);
    start = 1'b1; op = o; a = av; b = bv; flags_in = fv;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges (from 1 at the current one) until done is seen; -1 on timeout
  task automatic wait_done(output int l);
    int i;
    l = -1;
    i = 1;
    while (l < 0 && i <= 20) begin
      if (done === 1'b1) l = i;
      else begin
        @(negedge clk);
        i++;
      end
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() != 0) ex = exp_q.pop_front();
    else ex = 24'hxxxxxx;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (flags_out !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h want=00", flags_out); end
    total++; if ({alu_a, alu_b, alu_opcode, alu_cin} !== 22'd0) begin
      bad++; $display("FAIL reset_alu_idle got=%h/%h/%h/%b want=0", alu_a, alu_b, alu_opcode, alu_cin);
    end
  endtask

  task automatic test_add16();
    issue(3'd0, 16'habcd, 16'h0101, 8'hff, {16'hacce, 8'hec});
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add16_busy got=%b want=1", busy); end
    total++; if (alu_a !== 8'hcd || alu_b !== 8'h01) begin
      bad++; $display("FAIL add16_lo_operands got=%h/%h want=cd/01", alu_a, alu_b);
    end
    wait_done(lat);
    pop_exp();
    total++; if (lat != 3) begin bad++; $display("FAIL add16_latency got=%0d want=3", lat); end
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL add16_result got=%h want=%h", result, ex[23:8]); end
    total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL add16_flags got=%h want=%h", flags_out, ex[7:0]); end
  endtask

  task automatic test_adc16();
    issue(3'd1, 16'hffff, 16'h0000, 8'h01, {16'h0000, 8'h51});
    wait_done(lat);
    pop_exp();
    total++; if (lat != 3) begin bad++; $display("FAIL adc16_latency got=%0d want=3", lat); end
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL adc16_result got=%h want=%h", result, ex[23:8]); end
    total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL adc16_flags got=%h want=%h", flags_out, ex[7:0]); end
  endtask

  task automatic test_sbc16();
    logic [15:0] ta[2] = '{16'h1200, 16'h0000};
    logic [15:0] tb[2] = '{16'h0100, 16'h0001};
    logic [23:0] te[2] = '{{16'h1100, 8'h02}, {16'hffff, 8'hbb}};
    for (int i = 0; i < 2; i++) begin
      issue(3'd2, ta[i], tb[i], 8'h00, te[i]);
      wait_done(lat);
      pop_exp();
      total++; if (lat != 3) begin bad++; $display("FAIL sbc16_latency[%0d] got=%0d want=3", i, lat); end
      total++; if (result !== ex[23:8]) begin bad++; $display("FAIL sbc16_result[%0d] got=%h want=%h", i, result, ex[23:8]); end
      total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL sbc16_flags[%0d] got=%h want=%h", i, flags_out, ex[7:0]); end
    end
  endtask

  task automatic test_incdec();
    logic [2:0]  to[2] = '{3'd3, 3'd4};
    logic [15:0] ta[2] = '{16'hffff, 16'h0000};
    logic [15:0] tr[2] = '{16'h0000, 16'hffff};
    for (int i = 0; i < 2; i++) begin
      issue(to[i], ta[i], 16'h1234, 8'h5a, {tr[i], 8'h5a});
      wait_done(lat);
      pop_exp();
      total++; if (lat != INCDEC_LAT) begin bad++; $display("FAIL incdec_latency[%0d] got=%0d want=%0d", i, lat, INCDEC_LAT); end
      total++; if (result !== ex[23:8]) begin bad++; $display("FAIL incdec_result[%0d] got=%h want=%h", i, result, ex[23:8]); end
      total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL incdec_flags[%0d] got=%h want=%h", i, flags_out, ex[7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    start = 1'b1; op = 3'd2; a = 16'h5555; b = 16'h1111; flags_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_hi got=%b want=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_ctrl got=%b%b want=00", busy, done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rstmid_result got=%h want=0000", result); end
    total++; if (flags_out !== 8'h00) begin bad++; $display("FAIL rstmid_flags got=%h want=00", flags_out); end
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d pulses want=0", spurious); end
  endtask

  task automatic test_reserved();
    issue(3'd6, 16'hbeef, 16'h1111, 8'hc3, {16'hbeef, 8'hc3});
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reserved_busy got=%b want=0", busy); end
    wait_done(lat);
    pop_exp();
    total++; if (lat != 1) begin bad++; $display("FAIL reserved_latency got=%0d want=1", lat); end
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL reserved_result got=%h want=%h", result, ex[23:8]); end
    total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL reserved_flags got=%h want=%h", flags_out, ex[7:0]); end
    @(negedge clk);
    total++; if ({alu_a, alu_b, alu_opcode, alu_cin} !== 22'd0) begin
      bad++; $display("FAIL reserved_alu_idle got=%h/%h/%h/%b want=0", alu_a, alu_b, alu_opcode, alu_cin);
    end
  endtask

  task automatic test_back_to_back();
    int spurious;
    // Start held high through the whole first op
    start = 1'b1; op = 3'd0; a = 16'h1234; b = 16'h1111; flags_in = 8'h00;
    exp_q.push_back(ref16(3'd0, 16'h1234, 16'h1111, 8'h00));
    @(negedge clk);
    wait_done(lat);
    pop_exp();
    total++; if (lat != 3) begin bad++; $display("FAIL b2b_first_latency got=%0d want=3", lat); end
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", result, ex[23:8]); end
    op = 3'd2; a = 16'h8000; b = 16'h0001; flags_in = 8'h01;
    exp_q.push_back(ref16(3'd2, 16'h8000, 16'h0001, 8'h01));
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    pop_exp();
    total++; if (lat != 3) begin bad++; $display("FAIL b2b_gap got=%0d want=3", lat); end
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", result, ex[23:8]); end
    total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL b2b_second_flags got=%h want=%h", flags_out, ex[7:0]); end

    // Start pulsed during LO and HI must be ignored
    issue(3'd1, 16'h00ff, 16'h0001, 8'h00, ref16(3'd1, 16'h00ff, 16'h0001, 8'h00));
    start = 1'b1; op = 3'd0; a = 16'hffff; b = 16'hffff;
    @(negedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_busy_done got=%b want=1", done); end
    start = 1'b0;
    pop_exp();
    total++; if (result !== ex[23:8]) begin bad++; $display("FAIL b2b_busy_result got=%h want=%h", result, ex[23:8]); end
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL b2b_not_queued got=%0d pulses want=0", spurious); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [15:0] av, bv;
    logic [7:0]  fv;
    int          want_lat;
    for (int i = 0; i < 8; i++) begin
      o  = 3'($urandom_range(0, 4));
      av = 16'($urandom);
      bv = 16'($urandom);
      fv = 8'($urandom);
      want_lat = (o == 3'd3 || o == 3'd4) ? INCDEC_LAT : 3;
      issue(o, av, bv, fv, ref16(o, av, bv, fv));
      wait_done(lat);
      pop_exp();
      total++; if (lat != want_lat) begin bad++; $display("FAIL rand_latency[%0d] op=%0d got=%0d want=%0d", i, o, lat, want_lat); end
      total++; if (result !== ex[23:8]) begin bad++; $display("FAIL rand_result[%0d] op=%0d got=%h want=%h", i, o, result, ex[23:8]); end
      total++; if (flags_out !== ex[7:0]) begin bad++; $display("FAIL rand_flags[%0d] op=%0d got=%h want=%h", i, o, flags_out, ex[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_add16();
    test_adc16();
    test_sbc16();
    test_incdec();
    test_reset_mid();
    test_reserved();
    test_back_to_back();
    test_random();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Controller that performs Z80 16-bit arithmetic (ADD HL,rr / ADC HL,rr / SBC HL,rr / INC rr / DEC rr) by running the shared 8-bit `alu` twice: low byte, then high byte, with carry chained between the passes.
- Sits between the instruction decoder and the 8-bit ALU instance and owns the ALU input muxing while busy.
- Merges the two per-byte flag sets into one Z80 flag byte.

Parameters:
- DATA_W, 16, operand/result width; only 16 supported.
- ALU_W, 8, width of the sequenced ALU pass; only 8 supported.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0=ADD16, 1=ADC16, 2=SBC16, 3=INC16, 4=DEC16, 5-7 reserved.
- a  input  16  operand A (HL or rr).
- b  input  16  operand B (rr; ignored for INC16/DEC16).
- flags_in  input  8  current F register; layout S7 Z6 Y5 H4 X3 PV2 N1 C0.
- busy  output  1  high in LO and HI states.
- done  output  1  one-cycle pulse; result and flags_out valid.
- result  output  16  registered 16-bit result, held until the next done.
- flags_out  output  8  registered merged flags, held until the next done.
- alu_a  output  8  ALU operand A.
- alu_b  output  8  ALU operand B.
- alu_opcode  output  5  ALU opcode, from package constants.
- alu_cin  output  1  ALU carry/borrow in.
- alu_out  input  8  ALU result.
- alu_flags  input  8  ALU status_flag, same layout as flags_in.

Behaviour:
- States: IDLE, LO, HI, DONE.
- Transitions:
  - IDLE or DONE with start=1 and valid op goes to LO; operands and op are latched.
  - Reserved op goes directly to DONE with result=a and flags_out=flags_in.
  - LO goes to HI; HI goes to DONE.
  - DONE with no start goes to IDLE.
- Latency and throughput:
  - start at cycle 0 gives LO at 1, HI at 2, done=1 at 3.
  - Back-to-back start while done=1 is accepted, so throughput is one op per 3 cycles.
  - start while busy=1 is ignored (not queued).
- Reset: result=0, flags_out=0, done=0, busy=0, state=IDLE.
  - Reset mid-operation aborts; the partial result is discarded.
- ALU outputs while IDLE/DONE: alu_a=alu_b=0, alu_opcode=ALU_OP_ADD, alu_cin=0.
- LO pass, with alu_a=a[7:0]:
  - ADD16: ADD, b[7:0], cin=0.
  - ADC16: ADC, b[7:0], cin=flags_in.C.
  - SBC16: SBC, b[7:0], cin=flags_in.C.
  - INC16: ADD, 8'h01, cin=0.
  - DEC16: SUB, 8'h01, cin=0.
- LO end: latch lo_byte, lo_c and lo_z.
- HI pass, with alu_a=a[15:8] and cin=lo_c:
  - ADD16/ADC16/INC16: ADC.
  - SBC16/DEC16: SBC.
  - alu_b is b[15:8], or 8'h00 for INC16/DEC16.
- Flag merge:
  - Z = lo_z & hi_Z.
  - S, H, PV, N, C, Y, X are taken from the HI pass.
  - ADD16: S, Z, PV are preserved from flags_in.
  - INC16/DEC16: flags_out=flags_in (no flags affected).
- Wrap-around: 16'hFFFF+1 gives 16'h0000 and 16'h0000-1 gives 16'hFFFF; both are modulo 2^16 with carry/borrow reported in C.

Optional Feature:
- Macro ALU16_SEQ_INCDEC_BYPASS_EN.
- Defined: INC16/DEC16 use an internal 16-bit incrementer/decrementer and go IDLE to DONE directly (done at cycle 1); the ALU is untouched and busy stays 0.
- Undefined: INC16/DEC16 use the two-pass path described above (done at cycle 3).

Decomposition:
- Package z80_alu_pkg holds:
  - ALU opcode constants: ALU_OP_ADD=5'd0, ALU_OP_ADC=5'd1, ALU_OP_SUB=5'd2, ALU_OP_SBC=5'd3.
  - The seq op enum (3-bit).
  - Flag bit index constants FLAG_S..FLAG_C.
  - The state enum.
- The flag merge logic is a natural combinational sub-module, alu16_flag_merge.
- The ALU itself stays external.

Test Plan:
- ADD16 with a=16'habcd, b=16'h0101, flags_in=8'hFF -> done at cycle 3; result=16'hacce; C=0, N=0, H=0; S=Z=PV=1 preserved.
- ADC16 with a=16'hffff, b=16'h0000, C=1 -> result=16'h0000, Z=1, C=1, H=1, S=0.
- SBC16 with a=16'h1200, b=16'h0100, C=0 -> result=16'h1100, Z=0 (checks that low Z alone is not used); then a=16'h0000, b=16'h0001 -> 16'hFFFF with S=1, N=1, C=1.
- INC16 16'hFFFF -> 16'h0000; DEC16 16'h0000 -> 16'hFFFF; flags_out=flags_in=8'h5A in both.
- Back-to-back: start held high across done -> second done exactly 3 cycles after the first; start pulsed during busy -> ignored.
- Reset during HI -> next cycle busy=0, done=0, result=0, flags_out=0; no done pulse follows.
